// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings used by both
// the issue controller and the MDU datapath, plus the issue FSM states.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MFHI  = 3'b100;
  localparam logic [2:0] MDU_MTHI  = 3'b101;
  localparam logic [2:0] MDU_MFLO  = 3'b110;
  localparam logic [2:0] MDU_MTLO  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL_BUSY,
    ST_DIV_BUSY
  } state_t;

endpackage

// File: rtl/mdu_lat_cnt.sv
// Loadable latency down-counter; term flags the last busy cycle (count==1).
module mdu_lat_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             term
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign term = (count == CNT_W'(1));

endmodule

// File: rtl/mdu_issue.sv
// EX-stage issue/hazard controller for the multi-cycle MDU: issues ops,
// stalls MDU ops while a mult/div is in flight, returns HI/LO for mf*.
module mdu_issue
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 33,
  parameter int CNT_W    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op_ctrl,
  input  logic        flush,
  output logic        mdu_start,
  output logic [2:0]  mdu_ctrl,
  input  logic [31:0] mdu_hi,
  input  logic [31:0] mdu_lo,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        stall,
  output logic        busy,
  output logic [31:0] stall_cnt
);

  state_t           state_q, state_d;
  logic             req;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_term;
  logic             rd_take;
  logic [31:0]      stall_cnt_q;

  assign req  = op_valid & ~flush & ~rst;
  assign busy = (state_q != ST_IDLE) & ~rst;

  mdu_lat_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .term     (cnt_term)
  );

  // NOTE: every output of this block gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    mdu_start    = 1'b0;
    mdu_ctrl     = 3'b000;
    stall        = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    rd_take      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          case (op_ctrl)
            MDU_MULT, MDU_MULTU: begin
              mdu_start    = 1'b1;
              mdu_ctrl     = op_ctrl;
              cnt_load     = 1'b1;
              cnt_load_val = CNT_W'(MULT_LAT - 1);
              state_d      = ST_MUL_BUSY;
            end
            MDU_DIV, MDU_DIVU: begin
              mdu_start    = 1'b1;
              mdu_ctrl     = op_ctrl;
              cnt_load     = 1'b1;
              cnt_load_val = CNT_W'(DIV_LAT - 1);
              state_d      = ST_DIV_BUSY;
            end
            MDU_MTHI, MDU_MTLO: begin
              mdu_start = 1'b1;
              mdu_ctrl  = op_ctrl;
            end
            default: rd_take = 1'b1;
          endcase
        end
      end
      default: begin
        // Any MDU op waits until HI/LO settle; flush only masks req.
        stall = req;
        if (cnt_term) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_take;
      if (rd_take) rd_data <= (op_ctrl == MDU_MFHI) ? mdu_hi : mdu_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mdu_issue.sv
// Self-checking bench for mdu_issue: directed table, corner sequences and
// random traffic compared against a cycle-count reference model.
module tb_mdu_issue;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 33;

  localparam logic [2:0] OP_MULT  = 3'd0, OP_MULTU = 3'd1, OP_DIV  = 3'd2,
                         OP_DIVU  = 3'd3, OP_MFHI  = 3'd4, OP_MTHI = 3'd5,
                         OP_MFLO  = 3'd6, OP_MTLO  = 3'd7;

  logic        clk = 1'b0;
  logic        rst, op_valid, flush;
  logic [2:0]  op_ctrl;
  logic        mdu_start, rd_valid, stall, busy;
  logic [2:0]  mdu_ctrl;
  logic [31:0] mdu_hi, mdu_lo, rd_data, stall_cnt;

  always #5 clk = ~clk;

  mdu_issue #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op_ctrl   (op_ctrl),
    .flush     (flush),
    .mdu_start (mdu_start),
    .mdu_ctrl  (mdu_ctrl),
    .mdu_hi    (mdu_hi),
    .mdu_lo    (mdu_lo),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .stall     (stall),
    .busy      (busy),
    .stall_cnt (stall_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the MDU is busy while the cycle index is below the
  // cycle at which the last mult/div result becomes valid.
  longint      cyc      = 0;
  longint      busy_end = 0;
  logic        m_rdv;
  logic [31:0] m_rd_data, m_cnt;

  // Comb outputs as sampled in the most recent cycle.
  logic       s_start, s_stall, s_busy;
  logic [2:0] s_ctrl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [2:0] c, input logic f);
    logic req, mbusy, is_md, is_mt, is_mf, exp_start;
    rst      = r;
    op_valid = v;
    op_ctrl  = c;
    flush    = f;
    mdu_hi   = $urandom;
    mdu_lo   = $urandom;
    @(negedge clk);
    req       = v & ~f & ~r;
    mbusy     = !r && (cyc < busy_end);
    is_md     = (c <= 3'd3);
    is_mt     = (c == OP_MTHI) || (c == OP_MTLO);
    is_mf     = (c == OP_MFHI) || (c == OP_MFLO);
    exp_start = req && !mbusy && (is_md || is_mt);
    s_start = mdu_start;
    s_ctrl  = mdu_ctrl;
    s_stall = stall;
    s_busy  = busy;
    check("mdu_start", 32'(mdu_start), 32'(exp_start));
    check("mdu_ctrl",  32'(mdu_ctrl),  exp_start ? 32'(c) : 32'd0);
    check("stall",     32'(stall),     32'(req && mbusy));
    check("busy",      32'(busy),      32'(mbusy));
    if (r) begin
      busy_end  = 0;
      m_rdv     = 1'b0;
      m_rd_data = '0;
      m_cnt     = '0;
    end else begin
      m_rdv = req && !mbusy && is_mf;
      if (m_rdv) m_rd_data = (c == OP_MFHI) ? mdu_hi : mdu_lo;
      if (req && mbusy && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 1;
      if (req && !mbusy && is_md)
        busy_end = cyc + ((c >= OP_DIV) ? DIV_LAT : MULT_LAT);
    end
    @(posedge clk);
    #1;
    check("rd_valid",  32'(rd_valid), 32'(m_rdv));
    check("rd_data",   rd_data,       m_rd_data);
    check("stall_cnt", stall_cnt,     m_cnt);
    cyc++;
  endtask

  typedef struct {
    logic       r, v;
    logic [2:0] c;
    logic       f;
    logic       e_start, e_stall, e_busy, e_rdv;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int n_stall, n_term, n_start, n_rdv;

    // Mult, then dependent mfhi held through the stall.
    tbl[0] = '{1'b1, 1'b0, OP_MULT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, OP_MULT, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, OP_MFHI, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, OP_MFHI, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, OP_MFHI, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, OP_MFHI, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, OP_MFHI, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, OP_MULT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; op_valid = 1'b0; op_ctrl = '0; flush = 1'b0;
    mdu_hi = '0; mdu_lo = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].r, tbl[i].v, tbl[i].c, tbl[i].f);
      check("tbl_start", 32'(s_start),  32'(tbl[i].e_start));
      check("tbl_stall", 32'(s_stall),  32'(tbl[i].e_stall));
      check("tbl_busy",  32'(s_busy),   32'(tbl[i].e_busy));
      check("tbl_rdv",   32'(rd_valid), 32'(tbl[i].e_rdv));
    end
    check("mult_stall_cnt", stall_cnt, 32'd4);

    // divu then mflo held: 32 stall cycles, terminal flag once.
    cycle(1'b1, 1'b0, OP_MULT, 1'b0);
    cycle(1'b0, 1'b1, OP_DIVU, 1'b0);
    n_stall = 0;
    n_term  = int'(dut.u_cnt.term);
    for (int i = 0; i < DIV_LAT; i++) begin
      cycle(1'b0, 1'b1, OP_MFLO, 1'b0);
      n_stall += int'(s_stall);
      n_term  += int'(dut.u_cnt.term);
    end
    check("div_stalls", 32'(n_stall), 32'd32);
    check("div_term_once", 32'(n_term), 32'd1);
    check("div_rd_valid", 32'(rd_valid), 32'd1);
    cycle(1'b0, 1'b0, OP_MULT, 1'b0);

    // Back-to-back mthi, mtlo, mfhi in IDLE.
    n_start = 0;
    n_rdv   = 0;
    cycle(1'b0, 1'b1, OP_MTHI, 1'b0);
    n_start += int'(s_start);
    check("mthi_ctrl", 32'(s_ctrl), 32'(OP_MTHI));
    cycle(1'b0, 1'b1, OP_MTLO, 1'b0);
    n_start += int'(s_start);
    check("mtlo_ctrl", 32'(s_ctrl), 32'(OP_MTLO));
    cycle(1'b0, 1'b1, OP_MFHI, 1'b0);
    n_start += int'(s_start);
    n_rdv   += int'(rd_valid);
    cycle(1'b0, 1'b0, OP_MULT, 1'b0);
    n_rdv   += int'(rd_valid);
    check("mt_mf_starts", 32'(n_start), 32'd2);
    check("mt_mf_rdv", 32'(n_rdv), 32'd1);

    // Flushed mult is dropped; flush during MUL_BUSY does not abort.
    cycle(1'b0, 1'b1, OP_MULT, 1'b1);
    check("flush_no_start", 32'(s_start), 32'd0);
    cycle(1'b0, 1'b1, OP_MULTU, 1'b0);
    check("flush_idle_before", 32'(s_busy), 32'd0);
    cycle(1'b0, 1'b1, OP_MFLO, 1'b1);
    check("flush_busy_kept", 32'(s_busy), 32'd1);
    for (int i = 0; i < MULT_LAT - 2; i++) cycle(1'b0, 1'b0, OP_MULT, 1'b0);
    cycle(1'b0, 1'b1, OP_MFLO, 1'b0);
    check("flush_expire_stall", 32'(s_stall), 32'd0);
    check("flush_expire_rdv", 32'(rd_valid), 32'd1);

    // Reset at the third BUSY cycle of a div.
    cycle(1'b0, 1'b1, OP_DIV, 1'b0);
    cycle(1'b0, 1'b0, OP_MULT, 1'b0);
    cycle(1'b0, 1'b1, OP_MFHI, 1'b0);
    cycle(1'b1, 1'b1, OP_MFHI, 1'b0);
    check("rst_busy_low", 32'(s_busy), 32'd0);
    cycle(1'b0, 1'b1, OP_MULT, 1'b0);
    check("rst_then_mult_start", 32'(s_start), 32'd1);
    check("rst_then_mult_stall", 32'(s_stall), 32'd0);
    check("rst_cnt_zero", stall_cnt, 32'd0);

    // Saturation of the stall counter.
    dut.stall_cnt_q = 32'hFFFF_FFFE;
    m_cnt           = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, OP_MFHI, 1'b0);
    check("stall_cnt_sat", stall_cnt, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, OP_MULT, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0),
            ($urandom_range(0, 1) == 1),
            3'($urandom_range(0, 7)),
            ($urandom_range(0, 9) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mdu_issue.md
Name: mdu_issue

Overview:
- EX-stage issue/hazard controller for the multi-cycle multiply/divide unit; it is the initiator side of the MDU interface.
- Accepts decoded MDU ops from the pipeline and pulses start/ctrl into the MDU.
- Tracks MDU latency with a countdown and stalls the pipeline on any MDU op while a mult/div is in flight.
- Returns HI/LO to the pipeline for mfhi/mflo and keeps a saturating stall-cycle performance counter.

Parameters:
- MULT_LAT, 5, cycles from mult/multu issue until HI/LO are valid (legal range 2..63).
- DIV_LAT, 33, cycles from div/divu issue until HI/LO are valid (legal range 2..63).
- CNT_W, 6, countdown width; must hold max(MULT_LAT, DIV_LAT)-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- op_valid  in  1  an MDU op is present in EX this cycle.
- op_ctrl  in  3  op encoding: 000 mult, 001 multu, 010 div, 011 divu, 100 mfhi, 101 mthi, 110 mflo, 111 mtlo.
- flush  in  1  EX flush; masks op_valid this cycle.
- mdu_start  out  1  one-cycle issue strobe to the MDU.
- mdu_ctrl  out  3  op code to the MDU; meaningful only when mdu_start=1, else 000.
- mdu_hi  in  32  HI value from the MDU.
- mdu_lo  in  32  LO value from the MDU.
- rd_valid  out  1  registered; rd_data is valid for an accepted mfhi/mflo.
- rd_data  out  32  registered HI or LO.
- stall  out  1  combinational pipeline stall request.
- busy  out  1  a mult/div is in flight.
- stall_cnt  out  32  saturating count of cycles with stall=1.

Behaviour:
- Reset, synchronous: state=IDLE, count=0, rd_valid=0, rd_data=0, stall_cnt=0.
- While rst=1 all outputs read 0: mdu_start, stall and busy are forced low.
- Effective request: req = op_valid & ~flush & ~rst.
- States: IDLE, MUL_BUSY, DIV_BUSY. busy=1 in either BUSY state.
- IDLE, req with mult/multu: mdu_start=1 and mdu_ctrl=op_ctrl in the same cycle; count<=MULT_LAT-1; next state MUL_BUSY; stall=0.
- IDLE, req with div/divu: as above, but count<=DIV_LAT-1 and next state DIV_BUSY.
- IDLE, req with mthi/mtlo: mdu_start=1, mdu_ctrl=op_ctrl, remain IDLE, stall=0.
- IDLE, req with mfhi/mflo: no start, stall=0. Next edge: rd_valid<=1; rd_data<=mdu_hi for 100, mdu_lo for 110.
- BUSY state: count decrements every cycle.
  - If count==1, next state is IDLE.
  - Any req (all eight ops) gives stall=1, mdu_start=0, and the op is not accepted.
  - A stalled op is held by the pipeline and accepted in the first IDLE cycle.
- Latency: a mult issued in cycle t gives BUSY cycles t+1..t+MULT_LAT-1, so a dependent mfhi/mflo is accepted at cycle t+MULT_LAT. The same rule applies to div with DIV_LAT.
- rd_valid is high exactly one cycle per accepted mf*; otherwise 0. rd_data holds its last value.
- flush in any state only masks that cycle's input. An in-flight mult/div is not aborted and the countdown continues.
- stall_cnt increments on every cycle with stall=1 and saturates at 0xFFFFFFFF; it does not wrap.
- Reset mid-operation: returns to IDLE immediately and drops busy. The in-flight MDU result is undefined for software.
- mdu_start is never asserted in two consecutive cycles for mult/div, because BUSY follows issue.
- Back-to-back mt*/mf* ops in IDLE are each accepted in 1 cycle.

Decomposition:
- Shared package mdu_pkg holds:
  - the 3-bit op encodings (MDU_MULT … MDU_MTLO), shared with the MDU datapath;
  - the state enum.
- Sub-module mdu_lat_cnt: a loadable down-counter with a terminal flag (count==1). It is instantiated once.
- The FSM, read register and perf counter stay in mdu_issue.

Test Plan:
- Reset, then mult at t=10 -> mdu_start=1 and mdu_ctrl=000 at t=10. busy=1 for t=11..14. mfhi held from t=11 -> stall=1 for t=11..14 and accepted at t=15. rd_valid=1 at t=16 with rd_data=mdu_hi. stall_cnt=4.
- divu at t=0, then mflo held -> stall for 32 cycles (t=1..32), accepted at t=33, rd_data=mdu_lo at t=34. The countdown terminal flag is seen exactly once.
- IDLE: mthi, mtlo, mfhi on consecutive cycles -> two start pulses (ctrl 101, 111), no stall, one rd_valid pulse.
- mult with flush=1 -> no mdu_start, stays IDLE. A flush during MUL_BUSY -> busy is unchanged and the count still expires at t+MULT_LAT.
- rst asserted at the 3rd BUSY cycle of a div -> next cycle IDLE, busy=0, stall_cnt=0. A following mult issues without stall.
- Force stall_cnt to 0xFFFFFFFE and hold a stalled op for 3 cycles -> the counter reads 0xFFFFFFFF and stays there.
